l2_port_scheduler: RTL and testbench
====================================

L2_PORT_SCHEDULER -- requirements
Module: l2_port_scheduler

Interface
REQ-001 SHALL have parameter s_line, default 256, meaning L1/L2 line width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports l2_icache_read, l2_icache_write  input  1 each  icache miss request strobes.
REQ-005 SHALL have ports l2_icache_address  input  32, and l2_icache_wdata  input  s_line.
REQ-006 SHALL have ports l2_icache_resp  output  1, and l2_icache_rdata  output  s_line.
REQ-007 SHALL have ports l2_dcache_read, l2_dcache_write  input  1 each, l2_dcache_address  input  32, and l2_dcache_wdata  input  s_line.
REQ-008 SHALL have ports l2_dcache_resp  output  1, and l2_dcache_rdata  output  s_line.
REQ-009 SHALL have ports l2_read, l2_write  output  1 each, l2_address  output  32, and l2_wdata  output  s_line (all to the shared L2).
REQ-010 SHALL have ports l2_resp  input  1, and l2_rdata  input  s_line (from the shared L2).

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I and SERVE_D.
REQ-012 SHALL, in IDLE with a pending request on a port, latch that port's address, wdata and op, and enter SERVE_x on the next edge.
REQ-013 SHALL drive l2_read/l2_write, l2_address and l2_wdata from registers only, so a request sampled at edge N appears on the L2 port in cycle N+1 and stays stable until l2_resp.
REQ-014 SHALL, in SERVE_x with l2_resp=1, pulse the served port's resp for that same cycle, pass l2_rdata to that port's rdata, clear the L2 strobes, and return to IDLE.
REQ-015 SHALL hold the non-served port's resp at 0 and its request pending, with no loss, while the other port is in service.
REQ-016 SHALL treat read and write asserted together on one port as a write.
REQ-017 SHALL drive rdata outputs to 0 when the corresponding resp is 0.
REQ-018 SHALL ignore l2_resp in IDLE.
REQ-019 SHALL, on simultaneous icache and dcache requests in IDLE, grant per REQ-026/REQ-027.
REQ-020 SHALL keep minimum turnaround at one IDLE cycle between consecutive grants.
REQ-021 SHALL keep a 16-bit wrapping grant counter per port, incremented on each grant, for debug visibility through the shared package struct.

Reset
REQ-022 SHALL, on rst_n=0 at any time including mid-transaction, force IDLE asynchronously.
REQ-023 SHALL, on reset, force all outputs, latched address/data and grant counters to 0, and set the round-robin pointer to favour dcache.
REQ-024 SHALL drop any L2 transaction in flight at reset, without replay.
REQ-025 SHALL resume arbitration on the first edge after rst_n rises.

Configuration
REQ-026 SHALL, with macro L2_ARB_RR_EN defined, use round-robin on conflicts: grant the port not served last, and toggle the pointer on every grant.
REQ-027 SHALL, without L2_ARB_RR_EN, give dcache fixed priority on conflicts, with the pointer logic absent.

Structure
REQ-028 SHALL place the FSM state enum, the port-id typedef (PORT_I, PORT_D) and the latched-request struct (op, address, wdata) in shared package cache_arb_pkg.
REQ-029 SHALL implement the priority decision in one sub-module, l2_arb_grant: inputs are the two pending flags and the pointer; outputs are grant_valid and grant_id.

Verification
REQ-030 SHALL cover: icache read 0x0000_0040 alone, L2 responds 3 cycles after strobe -> l2_read high cycles 1-4, l2_icache_resp pulse with line data 0xA5..A5, then IDLE.
REQ-031 SHALL cover: icache and dcache reads in the same cycle, RR enabled, after reset -> dcache served first, icache granted after one IDLE cycle; repeated conflict alternates I/D.
REQ-032 SHALL cover: same as REQ-031 without L2_ARB_RR_EN -> dcache wins 4 consecutive conflicts and icache is served only when dcache is idle.
REQ-033 SHALL cover: dcache write 0x0000_1000, wdata 0xDEAD.., icache read pending -> l2_write with latched data stable until l2_resp, then icache read issued, with no spurious l2_icache_resp.
REQ-034 SHALL cover: rst_n asserted while in SERVE_I before l2_resp -> all outputs 0 immediately, FSM IDLE, and a late l2_resp ignored.
REQ-035 SHALL cover: a dcache request with read=1 and write=1 -> l2_write=1, l2_read=0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared types for the L2 port scheduler, which lets the icache and the
// dcache share a single L2 port.
//   arb_state_e : scheduler FSM states (IDLE, SERVE_I, SERVE_D)
//   port_id_e   : requesting port identifier (PORT_I, PORT_D)
//   l2_op_e     : operation latched for the L2 (none / read / write)
//   l2_req_t    : latched request (op, address, wdata)
//   grant_cnt_t : per-port 16-bit wrapping grant counters (debug)
// LINE_W is the widest line the latched-request struct can hold. The
// s_line parameter of l2_port_scheduler must not exceed it.
// ---------------------------------------------------------------------------
package cache_arb_pkg;

  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } l2_op_e;

  typedef struct packed {
    l2_op_e            op;
    logic [31:0]       address;
    logic [LINE_W-1:0] wdata;
  } l2_req_t;

  typedef struct packed {
    logic [15:0] grants_i;
    logic [15:0] grants_d;
  } grant_cnt_t;

  // Read and write asserted together is treated as a write.
  function automatic l2_op_e decode_op(input logic rd, input logic wr);
    if (wr)      return OP_WRITE;
    else if (rd) return OP_READ;
    else         return OP_NONE;
  endfunction

endpackage

// File: rtl/l2_arb_grant.sv
// ---------------------------------------------------------------------------
// l2_arb_grant
// Combinational priority decision between the icache and dcache ports.
// Ports:
//   pend_i, pend_d : request pending on the icache / dcache port
//   ptr            : port favoured when both are pending
//   grant_valid    : at least one port is pending
//   grant_id       : port that wins this decision
// A lone requester always wins. On a conflict the pointer decides, so
// fixed priority and round-robin differ only in how the pointer is driven.
// ---------------------------------------------------------------------------
module l2_arb_grant
  import cache_arb_pkg::*;
(
  input  logic     pend_i,
  input  logic     pend_d,
  input  port_id_e ptr,
  output logic     grant_valid,
  output port_id_e grant_id
);

  always_comb begin
    grant_valid = pend_i | pend_d;
    if (pend_i && pend_d) begin
      grant_id = ptr;
    end else if (pend_i) begin
      grant_id = PORT_I;
    end else begin
      grant_id = PORT_D;
    end
  end

endmodule

// File: rtl/l2_port_scheduler.sv
// ---------------------------------------------------------------------------
// l2_port_scheduler
// Shares one L2 port between the icache and dcache miss paths.
// Parameter:
//   s_line : line width in bits (must not exceed cache_arb_pkg::LINE_W)
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   l2_icache_read/write/address/wdata : icache request (held until resp)
//   l2_icache_resp, l2_icache_rdata  : icache completion, data when resp=1
//   l2_dcache_read/write/address/wdata : dcache request (held until resp)
//   l2_dcache_resp, l2_dcache_rdata  : dcache completion, data when resp=1
//   l2_read, l2_write, l2_address, l2_wdata : registered request to L2
//   l2_resp, l2_rdata                : completion and read data from L2
// Configuration macro:
//   L2_ARB_RR_EN : round-robin on conflicts. When undefined the dcache has
//                  fixed priority and no pointer register exists.
// ---------------------------------------------------------------------------
module l2_port_scheduler
  import cache_arb_pkg::*;
#(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              l2_icache_read,
  input  logic              l2_icache_write,
  input  logic [31:0]       l2_icache_address,
  input  logic [s_line-1:0] l2_icache_wdata,
  output logic              l2_icache_resp,
  output logic [s_line-1:0] l2_icache_rdata,

  input  logic              l2_dcache_read,
  input  logic              l2_dcache_write,
  input  logic [31:0]       l2_dcache_address,
  input  logic [s_line-1:0] l2_dcache_wdata,
  output logic              l2_dcache_resp,
  output logic [s_line-1:0] l2_dcache_rdata,

  output logic              l2_read,
  output logic              l2_write,
  output logic [31:0]       l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [s_line-1:0] l2_rdata
);

  arb_state_e state_q, state_d;
  l2_req_t    req_q, req_d;
  logic       l2_read_q, l2_read_d;
  logic       l2_write_q, l2_write_d;
  grant_cnt_t grant_cnt_q, grant_cnt_d;

  logic       pend_i, pend_d;
  logic       grant_valid;
  port_id_e   grant_id;
  port_id_e   rr_ptr;

  // The caches hold their strobes until they see resp, so a port that
  // loses arbitration simply stays pending; no extra queueing is needed.
  assign pend_i = l2_icache_read | l2_icache_write;
  assign pend_d = l2_dcache_read | l2_dcache_write;

`ifdef L2_ARB_RR_EN
  // Pointer names the port favoured on the next conflict.
  port_id_e rr_q, rr_d;
  assign rr_ptr = rr_q;
`else
  assign rr_ptr = PORT_D;
`endif

  l2_arb_grant u_grant (
    .pend_i      (pend_i),
    .pend_d      (pend_d),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Grants are taken only from IDLE, and every completion returns to IDLE,
  // which gives the single idle cycle between consecutive grants.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    l2_read_d   = l2_read_q;
    l2_write_d  = l2_write_q;
    grant_cnt_d = grant_cnt_q;
`ifdef L2_ARB_RR_EN
    rr_d        = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_d.wdata = '0;
          if (grant_id == PORT_I) begin
            state_d                   = SERVE_I;
            req_d.op                  = decode_op(l2_icache_read, l2_icache_write);
            req_d.address             = l2_icache_address;
            req_d.wdata[s_line-1:0]   = l2_icache_wdata;
            grant_cnt_d.grants_i      = grant_cnt_q.grants_i + 16'd1;
          end else begin
            state_d                   = SERVE_D;
            req_d.op                  = decode_op(l2_dcache_read, l2_dcache_write);
            req_d.address             = l2_dcache_address;
            req_d.wdata[s_line-1:0]   = l2_dcache_wdata;
            grant_cnt_d.grants_d      = grant_cnt_q.grants_d + 16'd1;
          end
          l2_read_d  = (req_d.op == OP_READ);
          l2_write_d = (req_d.op == OP_WRITE);
`ifdef L2_ARB_RR_EN
          rr_d = (grant_id == PORT_I) ? PORT_D : PORT_I;
`endif
        end
      end

      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d    = IDLE;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight L2 transaction; nothing is replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      l2_read_q   <= 1'b0;
      l2_write_q  <= 1'b0;
      grant_cnt_q <= '0;
`ifdef L2_ARB_RR_EN
      rr_q        <= PORT_D;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      l2_read_q   <= l2_read_d;
      l2_write_q  <= l2_write_d;
      grant_cnt_q <= grant_cnt_d;
`ifdef L2_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = req_q.address;
  assign l2_wdata   = req_q.wdata[s_line-1:0];

  // Completion is passed through in the same cycle as l2_resp; l2_resp
  // seen in IDLE matches neither serve state and is therefore ignored.
  assign l2_icache_resp  = (state_q == SERVE_I) && l2_resp;
  assign l2_dcache_resp  = (state_q == SERVE_D) && l2_resp;
  assign l2_icache_rdata = l2_icache_resp ? l2_rdata : '0;
  assign l2_dcache_rdata = l2_dcache_resp ? l2_rdata : '0;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_l2_port_scheduler
// Bench for l2_port_scheduler. Cache requesters hold strobes until resp and
// reissue from per-port stimulus queues; an L2 model answers after a set
// latency. Expected responses are pushed at issue time and popped on resp.
// ---------------------------------------------------------------------------
module tb_l2_port_scheduler;

  localparam int S_LINE = 256;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [31:0]       addr;
    logic [S_LINE-1:0] wdata;
    logic [S_LINE-1:0] rdata;
  } req_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              l2_icache_read, l2_icache_write;
  logic [31:0]       l2_icache_address;
  logic [S_LINE-1:0] l2_icache_wdata;
  logic              l2_icache_resp;
  logic [S_LINE-1:0] l2_icache_rdata;
  logic              l2_dcache_read, l2_dcache_write;
  logic [31:0]       l2_dcache_address;
  logic [S_LINE-1:0] l2_dcache_wdata;
  logic              l2_dcache_resp;
  logic [S_LINE-1:0] l2_dcache_rdata;
  logic              l2_read, l2_write;
  logic [31:0]       l2_address;
  logic [S_LINE-1:0] l2_wdata;
  logic              l2_resp;
  logic [S_LINE-1:0] l2_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int l2_cnt = 0;
  int lat = 3;
  bit model_en = 1'b1;

  req_t stim_i_q[$], stim_d_q[$], exp_i_q[$], exp_d_q[$];
  bit   order_q[$];
  logic [S_LINE-1:0] mem [logic [31:0]];
  logic [S_LINE-1:0] sh_mem [logic [31:0]];

  int                obs_cyc;
  logic              obs_ir, obs_dr, obs_read, obs_write;
  logic [S_LINE-1:0] obs_ird, obs_drd, obs_wdata;
  logic [31:0]       obs_addr;

  always #5 clk = ~clk;

  l2_port_scheduler #(.s_line(S_LINE)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .l2_icache_read    (l2_icache_read),
    .l2_icache_write   (l2_icache_write),
    .l2_icache_address (l2_icache_address),
    .l2_icache_wdata   (l2_icache_wdata),
    .l2_icache_resp    (l2_icache_resp),
    .l2_icache_rdata   (l2_icache_rdata),
    .l2_dcache_read    (l2_dcache_read),
    .l2_dcache_write   (l2_dcache_write),
    .l2_dcache_address (l2_dcache_address),
    .l2_dcache_wdata   (l2_dcache_wdata),
    .l2_dcache_resp    (l2_dcache_resp),
    .l2_dcache_rdata   (l2_dcache_rdata),
    .l2_read           (l2_read),
    .l2_write          (l2_write),
    .l2_address        (l2_address),
    .l2_wdata          (l2_wdata),
    .l2_resp           (l2_resp),
    .l2_rdata          (l2_rdata)
  );

  // Untouched L2 lines hold a byte pattern derived from the address
  // (address 0x40 gives 0xA5 in every byte).
  function automatic logic [S_LINE-1:0] def_line(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'hE5;
    return {(S_LINE/8){b}};
  endfunction

  function automatic logic [S_LINE-1:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return def_line(a);
  endfunction

  function automatic logic [S_LINE-1:0] sh_line(input logic [31:0] a);
    if (sh_mem.exists(a)) return sh_mem[a];
    return def_line(a);
  endfunction

  function automatic req_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [S_LINE-1:0] wd);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd; r.rdata = '0;
    return r;
  endfunction

  task automatic issue(input bit is_d, input req_t s);
    req_t e;
    e = s;
    e.rdata = s.wr ? '0 : sh_line(s.addr);
    if (s.wr) sh_mem[s.addr] = s.wdata;
    if (is_d) begin
      l2_dcache_read = s.rd; l2_dcache_write = s.wr;
      l2_dcache_address = s.addr; l2_dcache_wdata = s.wdata;
      exp_d_q.push_back(e);
    end else begin
      l2_icache_read = s.rd; l2_icache_write = s.wr;
      l2_icache_address = s.addr; l2_icache_wdata = s.wdata;
      exp_i_q.push_back(e);
    end
  endtask

  // One clock: sample outputs on the falling edge, then after the rising
  // edge update requesters and the L2 model.
  task automatic tick();
    @(negedge clk);
    obs_cyc = cyc;
    obs_ir = l2_icache_resp;  obs_ird = l2_icache_rdata;
    obs_dr = l2_dcache_resp;  obs_drd = l2_dcache_rdata;
    obs_read = l2_read; obs_write = l2_write;
    obs_addr = l2_address; obs_wdata = l2_wdata;
    @(posedge clk);
    #1;
    cyc++;
    if (obs_ir) begin l2_icache_read = 1'b0; l2_icache_write = 1'b0; end
    if (obs_dr) begin l2_dcache_read = 1'b0; l2_dcache_write = 1'b0; end
    if (!l2_dcache_read && !l2_dcache_write && stim_d_q.size() > 0) issue(1'b1, stim_d_q.pop_front());
    if (!l2_icache_read && !l2_icache_write && stim_i_q.size() > 0) issue(1'b0, stim_i_q.pop_front());
    if (model_en) begin
      if (l2_resp) begin
        l2_resp = 1'b0;
        l2_cnt = 0;
      end else if (l2_read || l2_write) begin
        l2_cnt++;
        if (l2_cnt == lat + 1) begin
          l2_resp = 1'b1;
          if (l2_write) mem[l2_address] = l2_wdata;
        end
      end
      if (l2_resp) l2_rdata = l2_read ? mem_line(l2_address) : '0;
      else         l2_rdata = {(S_LINE/32){32'hBAD0_0000 ^ 32'(cyc)}};
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    l2_icache_read = 1'b0; l2_icache_write = 1'b0;
    l2_icache_address = '0; l2_icache_wdata = '0;
    l2_dcache_read = 1'b0; l2_dcache_write = 1'b0;
    l2_dcache_address = '0; l2_dcache_wdata = '0;
    l2_resp = 1'b0; l2_rdata = {(S_LINE/32){32'hBAD0_BAD0}};
    stim_i_q.delete(); stim_d_q.delete(); exp_i_q.delete(); exp_d_q.delete(); order_q.delete();
    l2_cnt = 0; lat = 3; model_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l2_rdata = {(S_LINE/32){32'h1234_5678}};
    l2_resp = 1'b1;
    #1;
    vec_cnt++;
    if ({l2_read, l2_write, l2_icache_resp, l2_dcache_resp} !== 4'b0) begin
      err_cnt++;
      $display("[TB] FAIL reset_strobes: got %b, expected 0000", {l2_read, l2_write, l2_icache_resp, l2_dcache_resp});
    end
    vec_cnt++;
    if (l2_address !== 32'h0) begin
      err_cnt++; $display("[TB] FAIL reset_address: got %h, expected 0", l2_address);
    end
    vec_cnt++;
    if (l2_wdata !== '0) begin
      err_cnt++; $display("[TB] FAIL reset_wdata: got %h, expected 0", l2_wdata);
    end
    vec_cnt++;
    if ((l2_icache_rdata | l2_dcache_rdata) !== '0) begin
      err_cnt++; $display("[TB] FAIL reset_rdata: got %h, expected 0", l2_icache_rdata | l2_dcache_rdata);
    end
    do_reset();
    repeat (3) tick();
    vec_cnt++;
    if ({obs_read, obs_write, obs_ir, obs_dr} !== 4'b0) begin
      err_cnt++; $display("[TB] FAIL idle_after_reset: got %b, expected 0000", {obs_read, obs_write, obs_ir, obs_dr});
    end
  endtask

  task automatic test_icache_read();
    int c0, first_rd, last_rd, resp_cyc, nresp;
    req_t e;
    do_reset();
    first_rd = -1; last_rd = -1; resp_cyc = -1; nresp = 0;
    stim_i_q.push_back(mk(1'b1, 1'b0, 32'h0000_0040, '0));
    tick();
    c0 = cyc;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (obs_read) begin
        if (first_rd < 0) first_rd = obs_cyc - c0;
        last_rd = obs_cyc - c0;
      end
      vec_cnt++;
      if (obs_dr !== 1'b0) begin
        err_cnt++; $display("[TB] FAIL iread_no_dresp: got %b, expected 0 (cycle %0d)", obs_dr, obs_cyc - c0);
      end
      if (obs_ir) begin
        nresp++;
        resp_cyc = obs_cyc - c0;
        if (exp_i_q.size() == 0) begin
          vec_cnt++; err_cnt++; $display("[TB] FAIL iread_spurious_resp: got resp, expected none");
        end else begin
          e = exp_i_q.pop_front();
          vec_cnt++;
          if (obs_ird !== e.rdata) begin
            err_cnt++; $display("[TB] FAIL iread_rdata: got %h, expected %h", obs_ird, e.rdata);
          end
          vec_cnt++;
          if (obs_addr !== e.addr) begin
            err_cnt++; $display("[TB] FAIL iread_addr: got %h, expected %h", obs_addr, e.addr);
          end
        end
      end else begin
        vec_cnt++;
        if (obs_ird !== '0) begin
          err_cnt++; $display("[TB] FAIL iread_rdata_zero: got %h, expected 0", obs_ird);
        end
      end
    end
    vec_cnt++;
    if (first_rd !== 1 || last_rd !== 4) begin
      err_cnt++; $display("[TB] FAIL iread_window: got cycles %0d-%0d, expected 1-4", first_rd, last_rd);
    end
    vec_cnt++;
    if (resp_cyc !== 4 || nresp !== 1) begin
      err_cnt++; $display("[TB] FAIL iread_resp: got %0d pulses at cycle %0d, expected 1 at cycle 4", nresp, resp_cyc);
    end
  endtask

  task automatic test_conflict();
    int last_resp;
    logic prev_strobe, strobe;
    bit pid, want;
    req_t e;
    do_reset();
    last_resp = -1; prev_strobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stim_i_q.push_back(mk(1'b1, 1'b0, 32'h0000_0100 + 32'(i * 64), '0));
      stim_d_q.push_back(mk(1'b1, 1'b0, 32'h0000_2000 + 32'(i * 64), '0));
`ifdef L2_ARB_RR_EN
      order_q.push_back(1'b1);
      order_q.push_back(1'b0);
`endif
    end
`ifndef L2_ARB_RR_EN
    for (int i = 0; i < 4; i++) order_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) order_q.push_back(1'b0);
`endif
    for (int k = 0; k < 150 && order_q.size() > 0; k++) begin
      tick();
      strobe = obs_read | obs_write;
      if (strobe && !prev_strobe && last_resp >= 0) begin
        vec_cnt++;
        if (obs_cyc - last_resp !== 2) begin
          err_cnt++; $display("[TB] FAIL conflict_turnaround: got %0d cycles, expected 2", obs_cyc - last_resp);
        end
      end
      prev_strobe = strobe;
      if (obs_ir || obs_dr) begin
        last_resp = obs_cyc;
        vec_cnt++;
        if (obs_ir && obs_dr) begin
          err_cnt++; $display("[TB] FAIL conflict_dual_resp: got both, expected one");
        end
        pid = obs_dr;
        want = order_q.pop_front();
        vec_cnt++;
        if (pid !== want) begin
          err_cnt++; $display("[TB] FAIL conflict_order: got port %0d, expected port %0d (0=I 1=D)", pid, want);
        end
        if ((pid ? exp_d_q.size() : exp_i_q.size()) == 0) begin
          vec_cnt++; err_cnt++; $display("[TB] FAIL conflict_spurious_resp: got resp on port %0d, expected none", pid);
        end else begin
          e = pid ? exp_d_q.pop_front() : exp_i_q.pop_front();
          vec_cnt++;
          if ((pid ? obs_drd : obs_ird) !== e.rdata || obs_addr !== e.addr) begin
            err_cnt++; $display("[TB] FAIL conflict_data: got addr %h data %h, expected addr %h data %h",
                                obs_addr, pid ? obs_drd : obs_ird, e.addr, e.rdata);
          end
        end
      end
    end
    vec_cnt++;
    if (order_q.size() != 0 || exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
      err_cnt++; $display("[TB] FAIL conflict_timeout: got %0d services outstanding, expected 0", order_q.size());
    end
  endtask

  task automatic test_write_then_read();
    int nresp_i, nresp_d;
    req_t e;
    logic [S_LINE-1:0] dead;
    dead = {(S_LINE/32){32'hDEAD_BEEF}};
    do_reset();
    nresp_i = 0; nresp_d = 0;
    stim_d_q.push_back(mk(1'b0, 1'b1, 32'h0000_1000, dead));
    stim_i_q.push_back(mk(1'b1, 1'b0, 32'h0000_1000, '0));
    for (int k = 0; k < 40; k++) begin
      tick();
      if (obs_write) begin
        vec_cnt++;
        if (obs_addr !== 32'h0000_1000 || obs_wdata !== dead || obs_read !== 1'b0) begin
          err_cnt++; $display("[TB] FAIL wr_stable: got addr %h rd %b data %h, expected addr 00001000 rd 0 data %h",
                              obs_addr, obs_read, obs_wdata, dead);
        end
        vec_cnt++;
        if (obs_ir !== 1'b0) begin
          err_cnt++; $display("[TB] FAIL wr_no_iresp: got %b, expected 0", obs_ir);
        end
      end
      if (obs_dr && exp_d_q.size() > 0) begin
        nresp_d++;
        e = exp_d_q.pop_front();
        vec_cnt++;
        if (obs_drd !== e.rdata) begin
          err_cnt++; $display("[TB] FAIL wr_dresp_data: got %h, expected %h", obs_drd, e.rdata);
        end
      end
      if (obs_ir && exp_i_q.size() > 0) begin
        nresp_i++;
        e = exp_i_q.pop_front();
        vec_cnt++;
        if (nresp_d !== 1 || obs_ird !== e.rdata || obs_addr !== 32'h0000_1000) begin
          err_cnt++; $display("[TB] FAIL rd_after_wr: got dresps %0d addr %h data %h, expected 1 00001000 %h",
                              nresp_d, obs_addr, obs_ird, e.rdata);
        end
      end
    end
    vec_cnt++;
    if (nresp_i !== 1 || nresp_d !== 1) begin
      err_cnt++; $display("[TB] FAIL wr_rd_counts: got i=%0d d=%0d, expected i=1 d=1", nresp_i, nresp_d);
    end
  endtask

  task automatic test_rw_both();
    int nresp, nstrobe;
    req_t e;
    do_reset();
    nresp = 0; nstrobe = 0;
    stim_d_q.push_back(mk(1'b1, 1'b1, 32'h0000_3000, {(S_LINE/32){32'h0BAD_F00D}}));
    for (int k = 0; k < 15; k++) begin
      tick();
      if (obs_read || obs_write) begin
        nstrobe++;
        vec_cnt++;
        if ({obs_read, obs_write} !== 2'b01) begin
          err_cnt++; $display("[TB] FAIL rw_both_op: got read=%b write=%b, expected read=0 write=1", obs_read, obs_write);
        end
      end
      if (obs_dr && exp_d_q.size() > 0) begin
        nresp++;
        e = exp_d_q.pop_front();
        vec_cnt++;
        if (obs_drd !== e.rdata) begin
          err_cnt++; $display("[TB] FAIL rw_both_rdata: got %h, expected %h", obs_drd, e.rdata);
        end
      end
    end
    vec_cnt++;
    if (nresp !== 1 || nstrobe !== 4) begin
      err_cnt++; $display("[TB] FAIL rw_both_service: got %0d resp %0d strobe cycles, expected 1 and 4", nresp, nstrobe);
    end
  endtask

  task automatic test_reset_mid();
    int nresp;
    req_t e;
    do_reset();
    lat = 1000;
    stim_i_q.push_back(mk(1'b1, 1'b0, 32'h0000_0080, '0));
    repeat (3) tick();
    vec_cnt++;
    if (obs_read !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL mid_pre_reset: got l2_read %b, expected 1", obs_read);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({l2_read, l2_write, l2_icache_resp, l2_dcache_resp} !== 4'b0 || l2_address !== 32'h0 || l2_wdata !== '0) begin
      err_cnt++; $display("[TB] FAIL mid_async_reset: got strobes %b addr %h, expected 0000 0",
                          {l2_read, l2_write, l2_icache_resp, l2_dcache_resp}, l2_address);
    end
    l2_icache_read = 1'b0; l2_icache_write = 1'b0;
    stim_i_q.delete(); exp_i_q.delete();
    model_en = 1'b0; l2_cnt = 0; l2_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    l2_resp = 1'b1;
    l2_rdata = {(S_LINE/32){32'h5A5A_5A5A}};
    tick();
    vec_cnt++;
    if ({obs_ir, obs_dr, obs_read, obs_write} !== 4'b0 || obs_ird !== '0) begin
      err_cnt++; $display("[TB] FAIL mid_late_resp: got resp/strobes %b rdata %h, expected 0000 and 0",
                          {obs_ir, obs_dr, obs_read, obs_write}, obs_ird);
    end
    l2_resp = 1'b0;
    model_en = 1'b1; lat = 3;
    nresp = 0;
    stim_d_q.push_back(mk(1'b1, 1'b0, 32'h0000_2040, '0));
    for (int k = 0; k < 15; k++) begin
      tick();
      if (obs_dr && exp_d_q.size() > 0) begin
        nresp++;
        e = exp_d_q.pop_front();
        vec_cnt++;
        if (obs_drd !== e.rdata) begin
          err_cnt++; $display("[TB] FAIL mid_resume_rdata: got %h, expected %h", obs_drd, e.rdata);
        end
      end
    end
    vec_cnt++;
    if (nresp !== 1) begin
      err_cnt++; $display("[TB] FAIL mid_resume: got %0d responses, expected 1", nresp);
    end
  endtask

  initial begin
    l2_icache_read = 1'b0; l2_icache_write = 1'b0;
    l2_icache_address = '0; l2_icache_wdata = '0;
    l2_dcache_read = 1'b0; l2_dcache_write = 1'b0;
    l2_dcache_address = '0; l2_dcache_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    test_reset();
    test_icache_read();
    test_conflict();
    test_write_then_read();
    test_rw_both();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
